// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, EX state encoding and op classification helper
package alu_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLL  = 4'd2,
    SLT  = 4'd3,
    XOR  = 4'd4,
    SRL  = 4'd5,
    OR   = 4'd6,
    AND  = 4'd7,
    NDEF = 4'd8
  } alu_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == SLL) || (code == SRL);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// rtl/alu_shift_iter.sv - one-bit-per-cycle shift datapath (accumulator plus remaining-count)
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            load_left,
  input  logic [XLEN-1:0] load_val,
  input  logic [SHW-1:0]  load_cnt,
  output logic [XLEN-1:0] acc_next,
  output logic            last
);

  logic [XLEN-1:0] acc_q, acc_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            left_q, left_d;

  assign acc_next = left_q ? (acc_q << 1) : (acc_q >> 1);
  // The step taken while cnt==1 is the final one; acc_next is then the answer.
  assign last     = (cnt_q == SHW'(1));

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    left_d = left_q;
    if (load) begin
      acc_d  = load_val;
      cnt_d  = load_cnt;
      left_d = load_left;
    end else if (step) begin
      acc_d  = acc_next;
      cnt_d  = cnt_q - SHW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      left_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      left_q <= left_d;
    end
  end

endmodule

// File: rtl/alu_iter_exec.sv
// rtl/alu_iter_exec.sv - EX-stage ALU with valid/ready handshakes and iterative shifts
module alu_iter_exec
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ALUType,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic            sh_load, sh_step, sh_last;
  logic [XLEN-1:0] sh_next;

  assign shamt = src2[SHW-1:0];

  // Shift codes only land here with shamt==0, where the answer is src1 unchanged.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_type_e'(ALUType))
      ADD:     alu_res = src1 + src2;
      SUB:     alu_res = src1 - src2;
      SLL:     alu_res = src1;
      SRL:     alu_res = src1;
      SLT:     alu_res = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
      XOR:     alu_res = src1 ^ src2;
      OR:      alu_res = src1 | src2;
      AND:     alu_res = src1 & src2;
      default: alu_ill = 1'b1;
    endcase
  end

  alu_shift_iter #(.XLEN(XLEN), .SHW(SHW)) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .step      (sh_step),
    .load_left (ALUType == SLL),
    .load_val  (src1),
    .load_cnt  (shamt),
    .acc_next  (sh_next),
    .last      (sh_last)
  );

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    sh_load   = 1'b0;
    sh_step   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_shift(ALUType) && (shamt != '0)) begin
            sh_load   = 1'b1;
            illegal_d = 1'b0;
            state_d   = SHIFT;
          end else begin
            result_d  = alu_res;
            illegal_d = alu_ill;
            state_d   = DONE;
          end
        end
      end
      SHIFT: begin
        sh_step = 1'b1;
        if (sh_last) begin
          result_d = sh_next;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_iter_exec.sv
// tb/tb_alu_iter_exec.sv - directed self-checking bench for alu_iter_exec
module tb_alu_iter_exec;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUType;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int tests_run;
  int tests_failed;

  alu_iter_exec #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUType   (ALUType),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while IDLE; returns at a negedge one cycle after the hand-off.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                        input logic exp_ill);
    int lat;
    int rdy_seen;
    check({tag, "_ready_before"}, {31'b0, in_ready}, 32'd1);
    ALUType   = op;
    src1      = a;
    src2      = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    rdy_seen = 0;
    while (!out_valid && lat < 64) begin
      if (in_ready) rdy_seen++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"},  lat, exp_lat);
    check({tag, "_busy_rdy"}, rdy_seen, 32'd0);
    check({tag, "_result"},   result, exp_res);
    check({tag, "_zero"},     {31'b0, zero}, {31'b0, (exp_res == 32'd0)});
    check({tag, "_illegal"},  {31'b0, illegal}, {31'b0, exp_ill});
    check({tag, "_rdy_out"},  {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check({tag, "_back_idle"}, {in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    ALUType   = 4'd0;
    src1      = '0;
    src2      = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result",    result, 32'd0);
    check("rst_zero",      {31'b0, zero}, 32'd1);
    check("rst_illegal",   {31'b0, illegal}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0000, 1'b0);
    run_op("slt_neg",  4'd3, 32'hFFFF_FFFE, 32'h0000_0003, 1, 32'h0000_0001, 1'b0);
    run_op("sub_neg",  4'd1, 32'd5,         32'd7,         1, 32'hFFFF_FFFE, 1'b0);
    run_op("xor",      4'd4, 32'hFF00_FF00, 32'h0F0F_0F0F, 1, 32'hF00F_F00F, 1'b0);
    run_op("or",       4'd6, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1, 32'hFFFF_FFFF, 1'b0);
    run_op("sll_31",   4'd2, 32'h0000_0001, 32'h0000_001F, 32, 32'h8000_0000, 1'b0);
    run_op("srl_4",    4'd5, 32'h8000_0000, 32'h0000_0004, 5, 32'h0800_0000, 1'b0);
    run_op("sll_0",    4'd2, 32'h1234_5678, 32'h0000_0020, 1, 32'h1234_5678, 1'b0);
    run_op("ndef_8",   4'd8, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1, 32'h0000_0000, 1'b1);
    run_op("ndef_12",  4'd12, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1, 32'h0000_0000, 1'b1);

    // Backpressure: hold AND result, then a held request is accepted on the IDLE cycle.
    ALUType   = 4'd7;
    src1      = 32'hF0F0_F0F0;
    src2      = 32'hFF00_FF00;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ALUType = 4'd0;
    src1    = 32'd2;
    src2    = 32'd3;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",  {31'b0, out_valid}, 32'd1);
      check("bp_result", result, 32'hF000_F000);
      check("bp_ready",  {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_idle", {in_ready, out_valid}, 32'b10);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_valid",  {31'b0, out_valid}, 32'd1);
    check("bp_second_result", result, 32'd5);
    @(negedge clk);

    // Reset in the middle of a 20-step shift.
    ALUType  = 4'd2;
    src1     = 32'h0000_0001;
    src2     = 32'd20;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_shift_busy", {in_ready, out_valid}, 32'b00);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mrst_in_ready",  {31'b0, in_ready}, 32'd1);
    check("mrst_result",    result, 32'd0);
    check("mrst_zero",      {31'b0, zero}, 32'd1);
    rst = 1'b0;
    run_op("add_after_rst", 4'd0, 32'd2, 32'd3, 1, 32'd5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
